// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch unit execute, instruction-memory and decode-slot signals
// master drives the execute/memory/stall inputs; slave is the fetch unit itself.
interface pc_fetch_unit_if;
  logic        ex_valid;
  logic [31:0] ex_instr;
  logic [31:0] ex_pc;
  logic [31:0] rs1Data;
  logic        Branch;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect;
  logic        misalign;

  modport master (
    output ex_valid, ex_instr, ex_pc, rs1Data, Branch, stall, imem_ready, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, redirect, misalign
  );

  modport slave (
    input  ex_valid, ex_instr, ex_pc, rs1Data, Branch, stall, imem_ready, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_instr, redirect, misalign
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and single-slot instruction fetch controller
// Resolves branch/jal/jalr redirects from execute and holds one fetched instruction for decode.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst,
  pc_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        misalign_q, misalign_d;

  logic [31:0] imm_b, imm_j, imm_i;
  logic [31:0] tgt;
  logic        redirect;
  logic        slot_free;
  logic        req;
  logic        capture;

  always_comb begin
    imm_b    = {{19{bus.ex_instr[31]}}, bus.ex_instr[31], bus.ex_instr[7],
                bus.ex_instr[30:25], bus.ex_instr[11:8], 1'b0};
    imm_j    = {{11{bus.ex_instr[31]}}, bus.ex_instr[31], bus.ex_instr[19:12],
                bus.ex_instr[20], bus.ex_instr[30:21], 1'b0};
    imm_i    = {{20{bus.ex_instr[31]}}, bus.ex_instr[31:20]};
    tgt      = 32'h0;
    redirect = 1'b0;
    if (bus.ex_valid) begin
      if (bus.ex_instr[6:0] == OP_BRANCH && bus.Branch) begin
        redirect = 1'b1;
        tgt      = bus.ex_pc + imm_b;
      end else if (bus.ex_instr[6:0] == OP_JAL) begin
        redirect = 1'b1;
        tgt      = bus.ex_pc + imm_j;
      end else if (bus.ex_instr[6:0] == OP_JALR && bus.ex_instr[14:12] == 3'b000) begin
        redirect = 1'b1;
        tgt      = (bus.rs1Data + imm_i) & ~32'h1;
      end
    end
  end

  // The slot can take a new word when empty or when decode drains it this cycle.
  always_comb begin
    slot_free = !if_valid_q || !bus.stall;
    req       = !rst && (state_q != BOOT) && slot_free;
    capture   = req && bus.imem_ready && !redirect;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    misalign_d = 1'b0;
    if (redirect) begin
      pc_d       = tgt;
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      state_d    = RUN;
      misalign_d = tgt[1];
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN, HOLD: begin
          if (capture) begin
            if_instr_d = bus.imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end else if (if_valid_q && !bus.stall) begin
            if_valid_d = 1'b0;
          end
          state_d = (if_valid_q && bus.stall) ? HOLD : RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP_INSTR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.redirect  = redirect;
  assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed bench for pc_fetch_unit
// Memory model returns 0xA0000000 ^ address so every captured word identifies its fetch PC.
module tb_pc_fetch_unit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.imem_rdata = 32'hA000_0000 ^ bus.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ex_drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic br);
    bus.ex_valid = v;
    bus.ex_instr = instr;
    bus.ex_pc    = pc;
    bus.rs1Data  = rs1;
    bus.Branch   = br;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    bus.stall  = 1'b0;
    bus.imem_ready = 1'b1;
    ex_drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    check_eq("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check_eq("rst_valid", {31'b0, bus.if_valid}, 32'd0);
    check_eq("rst_instr", bus.if_instr, 32'h0000_0013);
    check_eq("rst_pc", bus.if_pc, 32'h0);
    check_eq("rst_addr", bus.imem_addr, 32'h0);
    check_eq("rst_misalign", {31'b0, bus.misalign}, 32'd0);

    // sequential fetch
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("boot_req", {31'b0, bus.imem_req}, 32'd0);
    tick();
    check_eq("run_valid0", {31'b0, bus.if_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check_eq("seq_addr", bus.imem_addr, 32'(4 * k));
      check_eq("seq_req", {31'b0, bus.imem_req}, 32'd1);
      tick();
      check_eq("seq_if_pc", bus.if_pc, 32'(4 * k));
      check_eq("seq_instr", bus.if_instr, 32'hA000_0000 ^ 32'(4 * k));
      check_eq("seq_valid", {31'b0, bus.if_valid}, 32'd1);
    end

    // beq taken / not taken
    ex_drive(1'b1, 32'h0020_8463, 32'h100, 32'h0, 1'b1);
    #1;
    check_eq("beq_redirect", {31'b0, bus.redirect}, 32'd1);
    tick();
    ex_drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    check_eq("beq_addr", bus.imem_addr, 32'h108);
    check_eq("beq_valid", {31'b0, bus.if_valid}, 32'd0);
    check_eq("beq_nop", bus.if_instr, 32'h0000_0013);
    ex_drive(1'b1, 32'h0020_8463, 32'h100, 32'h0, 1'b0);
    #1;
    check_eq("bne_redirect", {31'b0, bus.redirect}, 32'd0);
    tick();
    ex_drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    check_eq("bne_addr", bus.imem_addr, 32'h10C);
    check_eq("bne_if_pc", bus.if_pc, 32'h108);

    // jal backwards
    ex_drive(1'b1, 32'hFFDF_F06F, 32'h200, 32'h0, 1'b0);
    #1;
    check_eq("jal_redirect", {31'b0, bus.redirect}, 32'd1);
    tick();
    ex_drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    check_eq("jal_addr", bus.imem_addr, 32'h1FC);
    check_eq("jal_valid", {31'b0, bus.if_valid}, 32'd0);
    check_eq("jal_misalign", {31'b0, bus.misalign}, 32'd0);

    // jalr to a half-word aligned target
    ex_drive(1'b1, 32'h0032_8067, 32'h300, 32'h1000, 1'b0);
    tick();
    ex_drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    check_eq("jalr_addr", bus.imem_addr, 32'h1002);
    check_eq("jalr_misalign", {31'b0, bus.misalign}, 32'd1);
    tick();
    check_eq("jalr_misalign_drop", {31'b0, bus.misalign}, 32'd0);
    check_eq("jalr_if_pc", bus.if_pc, 32'h1002);
    check_eq("jalr_next_addr", bus.imem_addr, 32'h1006);

    // decode stall
    bus.stall = 1'b1;
    #1;
    check_eq("stall_req", {31'b0, bus.imem_req}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("hold_if_pc", bus.if_pc, 32'h1002);
      check_eq("hold_instr", bus.if_instr, 32'hA000_1002);
      check_eq("hold_req", {31'b0, bus.imem_req}, 32'd0);
      check_eq("hold_addr", bus.imem_addr, 32'h1006);
    end
    bus.stall = 1'b0;
    #1;
    check_eq("release_req", {31'b0, bus.imem_req}, 32'd1);
    tick();
    check_eq("release_if_pc", bus.if_pc, 32'h1006);
    check_eq("release_instr", bus.if_instr, 32'hA000_1006);

    // memory wait states
    bus.imem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq("wait_addr", bus.imem_addr, 32'h100A);
      check_eq("wait_req", {31'b0, bus.imem_req}, 32'd1);
      check_eq("wait_valid", {31'b0, bus.if_valid}, 32'd0);
    end
    bus.imem_ready = 1'b1;
    tick();
    check_eq("wait_if_pc", bus.if_pc, 32'h100A);
    check_eq("wait_valid_back", {31'b0, bus.if_valid}, 32'd1);

    // asynchronous reset mid-run
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_req", {31'b0, bus.imem_req}, 32'd0);
    check_eq("arst_valid", {31'b0, bus.if_valid}, 32'd0);
    check_eq("arst_instr", bus.if_instr, 32'h0000_0013);
    check_eq("arst_if_pc", bus.if_pc, 32'h0);
    check_eq("arst_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("arst_boot_req", {31'b0, bus.imem_req}, 32'd0);
    tick();
    check_eq("arst_first_addr", bus.imem_addr, 32'h0);
    check_eq("arst_first_req", {31'b0, bus.imem_req}, 32'd1);
    tick();
    check_eq("arst_first_if_pc", bus.if_pc, 32'h0);
    check_eq("arst_next_addr", bus.imem_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
